// File: rtl/data_mem_if.sv
// Shared types and bus bundle for the synchronous-read data memory.
// Only bit 1 of the address-source select matters to the memory.
package data_mem_pkg;
  typedef logic [1:0] data_src_t;
  localparam data_src_t SRC_MEM_ADDR = 2'b00;
  localparam data_src_t SRC_INDIRECT = 2'b10;
endpackage

interface data_mem_if #(
  parameter int WIDTH   = 8,
  parameter int A_WIDTH = 10
);
  logic [A_WIDTH-1:0]     addr_id;
  logic [A_WIDTH-1:0]     addr_rf;
  data_mem_pkg::data_src_t a_source;
  logic                   req;
  logic                   we;
  logic [WIDTH-1:0]       wdata;
  logic                   clear;
  logic                   ready;
  logic [WIDTH-1:0]       rdata;
  logic                   rvalid;

  modport master (
    output addr_id, addr_rf, a_source, req, we, wdata, clear,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  addr_id, addr_rf, a_source, req, we, wdata, clear,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/data_mem.sv
// Synchronous-read data memory with req/ready handshake, registered read data
// and a zero-clear sequencer that runs after reset or on request.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready=1, serves read/write requests, clear starts a sweep
// ST_CLEAR | ready=0, writes zero to mem[cnt] each cycle, cnt 0..N-1
module data_mem #(
  parameter int WIDTH          = 8,
  parameter int A_WIDTH        = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  data_mem_if.slave   bus
);

  localparam int                 N        = 2 ** A_WIDTH;
  localparam logic [A_WIDTH-1:0] LAST_ADR = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [A_WIDTH-1:0] cnt;
  logic [A_WIDTH-1:0] cnt_nxt;
  logic [A_WIDTH-1:0] acc_addr;
  logic [A_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;
  logic               mem_we;
  logic               rd_en;
  logic [WIDTH-1:0]   rdata_q;
  logic               rvalid_q;
  logic [WIDTH-1:0]   mem [N];

  assign acc_addr = bus.a_source[1] ? bus.addr_rf : bus.addr_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    mem_waddr = acc_addr;
    mem_wdata = bus.wdata;
    rd_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // clear outranks a coincident request; the request is simply dropped
        if (bus.clear) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end else if (bus.req) begin
          if (bus.we) mem_we = 1'b1;
          else        rd_en  = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = '0;
        if (cnt == LAST_ADR) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + A_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Storage itself is never reset; writes are simply suppressed while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= mem[acc_addr];
    end
  end

  assign bus.ready  = (state == ST_IDLE);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed scenarios plus random traffic against an
// array-based reference model; a second instance covers CLEAR_ON_RESET=0.
module tb_data_mem;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst0_n;

  data_mem_if #(.WIDTH(W), .A_WIDTH(AW)) bus  ();
  data_mem_if #(.WIDTH(W), .A_WIDTH(AW)) bus0 ();

  data_mem #(.WIDTH(W), .A_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  data_mem #(.WIDTH(W), .A_WIDTH(AW), .CLEAR_ON_RESET(0)) dut0 (
    .clk  (clk),
    .rst_n(rst0_n),
    .bus  (bus0)
  );

  // reference model: plain array plus "words still to clear"
  logic [W-1:0] m_mem [N];
  int           clear_left;
  logic [W-1:0] m_rdata;
  logic         m_rvalid;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input logic r, input logic rq, input logic w, input logic cl,
                      input logic [1:0] src, input logic [AW-1:0] aid,
                      input logic [AW-1:0] arf, input logic [W-1:0] wd);
    logic [AW-1:0] a;
    rst_n        = r;
    bus.req      = rq;
    bus.we       = w;
    bus.clear    = cl;
    bus.a_source = src;
    bus.addr_id  = aid;
    bus.addr_rf  = arf;
    bus.wdata    = wd;
    a = src[1] ? arf : aid;
    if (!r) begin
      clear_left = N;
      m_rdata    = '0;
      m_rvalid   = 1'b0;
    end else if (clear_left > 0) begin
      m_mem[N - clear_left] = '0;
      clear_left--;
      m_rvalid = 1'b0;
    end else if (cl) begin
      clear_left = N;
      m_rvalid   = 1'b0;
    end else if (rq && w) begin
      m_mem[a] = wd;
      m_rvalid = 1'b0;
    end else if (rq) begin
      m_rdata  = m_mem[a];
      m_rvalid = 1'b1;
    end else begin
      m_rvalid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("ready",  32'(bus.ready),  32'(clear_left == 0));
    check("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    check("rdata",  32'(bus.rdata),  32'(m_rdata));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0);
  endtask

  task automatic count_ready_low(input string tag);
    int low = 0;
    for (int i = 0; i < 40 && bus.ready !== 1'b1; i++) begin
      idle();
      if (bus.ready !== 1'b1 || i == 0) low++;
    end
    check(tag, 32'(low), 32'(N));
  endtask

  task automatic step0(input logic r, input logic rq, input logic w, input logic cl,
                       input logic [1:0] src, input logic [AW-1:0] aid,
                       input logic [AW-1:0] arf, input logic [W-1:0] wd);
    rst0_n        = r;
    bus0.req      = rq;
    bus0.we       = w;
    bus0.clear    = cl;
    bus0.a_source = src;
    bus0.addr_id  = aid;
    bus0.addr_rf  = arf;
    bus0.wdata    = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int low;
    clear_left = N;
    m_rdata    = '0;
    m_rvalid   = 1'b0;
    rst0_n = 1'b0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.clear = 1'b0; bus0.a_source = 2'b00;
    bus0.addr_id = '0; bus0.addr_rf = '0; bus0.wdata = '0;

    // reset two cycles, then ready must stay low for exactly N cycles
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'd1, '0, 8'hFF);
    check("reset_ready", 32'(bus.ready), 32'd0);
    low = 0;
    for (int i = 0; i < 40 && bus.ready !== 1'b1; i++) begin
      idle();
      if (bus.ready !== 1'b1) low++;
    end
    check("clear_low_cycles", 32'(low + 1), 32'(N));

    // every word reads back zero
    for (int i = 0; i < N; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, AW'(i), AW'(N - 1 - i), 8'hEE);
      check("cleared_word", 32'(bus.rdata), 32'd0);
    end
    idle();

    // direct write, indirect read
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 4'd3, 4'd12, 8'hA5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 4'd9, 4'd3, 8'h00);
    check("indirect_rdata", 32'(bus.rdata), 32'hA5);
    check("indirect_rvalid", 32'(bus.rvalid), 32'd1);
    idle();
    check("rvalid_falls", 32'(bus.rvalid), 32'd0);

    // back-to-back write/read/write/read at address 5
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd5, 4'd0, 8'h11);
    check("b2b_rvalid0", 32'(bus.rvalid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 4'd0, 4'd5, 8'h00);
    check("b2b_rd1", 32'(bus.rdata), 32'h11);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd5, 4'd0, 8'h22);
    check("b2b_hold", 32'(bus.rdata), 32'h11);
    check("b2b_rvalid2", 32'(bus.rvalid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd5, 4'd0, 8'h00);
    check("b2b_rd2", 32'(bus.rdata), 32'h22);

    // clear and write on the same edge: clear wins, requests ignored while clearing
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 4'd2, 4'd0, 8'h7F);
    for (int i = 0; i < N; i++)
      step(1'b1, 1'b1, 1'(i % 2), 1'b0, 2'b00, 4'd2, 4'd2, 8'h7F);
    check("after_clear_ready", 32'(bus.ready), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd2, 4'd0, 8'h00);
    check("dropped_write", 32'(bus.rdata), 32'd0);

    // reset in the middle of a clear sweep restarts it
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd7, 4'd0, 8'h5A);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd7, 4'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 8'h00);
    for (int i = 0; i < 9; i++) idle();
    check("clear_holds_rdata", 32'(bus.rdata), 32'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 8'h00);
    check("midclr_rst_rdata", 32'(bus.rdata), 32'd0);
    check("midclr_rst_rvalid", 32'(bus.rvalid), 32'd0);
    low = 0;
    for (int i = 0; i < 40 && bus.ready !== 1'b1; i++) begin
      idle();
      if (bus.ready !== 1'b1) low++;
    end
    check("midclr_low_cycles", 32'(low + 1), 32'(N));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
           AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)),
           W'($urandom_range(0, 255)));
    end

    // CLEAR_ON_RESET=0 instance
    step0(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0);
    check("nc_reset_ready", 32'(bus0.ready), 32'd1);
    check("nc_reset_rdata", 32'(bus0.rdata), 32'd0);
    check("nc_reset_rvalid", 32'(bus0.rvalid), 32'd0);
    step0(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd15, 4'd0, 8'h3C);
    check("nc_wr_ready", 32'(bus0.ready), 32'd1);
    check("nc_wr_rvalid", 32'(bus0.rvalid), 32'd0);
    step0(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 4'd0, 4'd15, 8'h00);
    check("nc_rd_rdata", 32'(bus0.rdata), 32'h3C);
    check("nc_rd_rvalid", 32'(bus0.rvalid), 32'd1);
    step0(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 8'h00);
    check("nc_clear_rvalid", 32'(bus0.rvalid), 32'd0);
    low = 0;
    for (int i = 0; i < 40 && bus0.ready !== 1'b1; i++) begin
      step0(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd15, 4'd0, 8'h99);
      if (bus0.ready !== 1'b1) low++;
    end
    check("nc_clear_low_cycles", 32'(low + 1), 32'(N));
    step0(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd15, 4'd0, 8'h00);
    check("nc_after_clear", 32'(bus0.rdata), 32'd0);
    check("nc_after_clear_rv", 32'(bus0.rvalid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
